// File: rtl/nlprg_pkg.sv
// Shared types and constants for the 5-bit nonlinear (de Bruijn) generator.
package nlprg_pkg;
  localparam int NLPRG_W = 5;

  typedef logic [NLPRG_W-1:0] nlprg_state_t;

  // Feedback taps of x^5+x^2+1: state bits 4 and 2
  localparam nlprg_state_t NLPRG_TAPS = 5'b10100;
  localparam nlprg_state_t NLPRG_SEED = 5'b00000;
endpackage

// File: rtl/nlprg_fb.sv
// Next-state function: LFSR tap XOR plus zero-detect correction that
// splices 00000 into the cycle between 10000 and 00001.
module nlprg_fb
  import nlprg_pkg::*;
(
  input  nlprg_state_t state_i,
  output nlprg_state_t nxt_o
);
  logic lo_zero;
  logic fb;

  assign lo_zero = (state_i[NLPRG_W-2:0] == '0);
  assign fb      = (^(state_i & NLPRG_TAPS)) ^ lo_zero;
  assign nxt_o   = {state_i[NLPRG_W-2:0], fb};
endmodule

// File: rtl/nlprg_5.sv
// 5-bit full-period (32-state) pseudo-random generator; o is the state register.
// Optional step enable input en when NLPRG_STEP_EN is defined.
module nlprg_5
  import nlprg_pkg::*;
#(
  parameter nlprg_state_t SEED = NLPRG_SEED
) (
  input  logic         ck,
  input  logic         rst,
`ifdef NLPRG_STEP_EN
  input  logic         en,
`endif
  output nlprg_state_t o
);
  nlprg_state_t s_q, s_d, nxt;

  nlprg_fb u_fb (
    .state_i (s_q),
    .nxt_o   (nxt)
  );

`ifdef NLPRG_STEP_EN
  always_comb begin
    s_d = s_q;
    if (en) s_d = nxt;
  end
`else
  always_comb begin
    s_d = nxt;
  end
`endif

  always_ff @(posedge ck or posedge rst) begin
    if (rst) s_q <= SEED;
    else     s_q <= s_d;
  end

  assign o = s_q;
endmodule

// File: tb/tb_nlprg_5.sv
// Directed bench for nlprg_5: reset, first values, full period, wrap,
// mid-run async reset and (with NLPRG_STEP_EN) step enable.
module tb_nlprg_5;
  logic       ck = 1'b0;
  logic       rst = 1'b0;
`ifdef NLPRG_STEP_EN
  logic       en = 1'b1;
`endif
  logic [4:0] o;

  int n_chk  = 0;
  int n_pass = 0;

  // Hand-derived sequence after reset release: entry i is o after clock i+1
  logic [4:0] exp_seq [32] = '{
    5'd1,  5'd2,  5'd4,  5'd9,  5'd18, 5'd5,  5'd11, 5'd22,
    5'd12, 5'd25, 5'd19, 5'd7,  5'd15, 5'd31, 5'd30, 5'd28,
    5'd24, 5'd17, 5'd3,  5'd6,  5'd13, 5'd27, 5'd23, 5'd14,
    5'd29, 5'd26, 5'd21, 5'd10, 5'd20, 5'd8,  5'd16, 5'd0
  };

  nlprg_5 dut (
    .ck  (ck),
    .rst (rst),
`ifdef NLPRG_STEP_EN
    .en  (en),
`endif
    .o   (o)
  );

  always #5 ck = ~ck;

  task automatic chk(input string tag, input logic [4:0] got, input logic [4:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // One rising edge, then settle to the falling edge for sampling
  task automatic step();
    @(posedge ck);
    @(negedge ck);
  endtask

  initial begin
    logic [31:0] seen;
    int          nd;

    // Async reset with no clock edge yet (first posedge at t=5)
    #1 rst = 1'b1;
    #1 chk("rst_async", o, 5'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst_hold", o, 5'd0);
    end
    rst = 1'b0;

    // 96 clocks: first 32 give the full period, then two identical repeats
    seen = '0;
    for (int i = 0; i < 96; i++) begin
      step();
      chk($sformatf("seq%0d", i + 1), o, exp_seq[i % 32]);
      if (i < 32) seen[o] = 1'b1;
    end
    nd = $countones(seen);
    n_chk++;
    if (nd == 32) n_pass++;
    else $display("FAIL distinct: got %0d distinct values expected 32", nd);

    // Mid-run reset after clock 13
    @(negedge ck);
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 13; i++) step();
    chk("pre_midrst", o, exp_seq[12]);
    #2 rst = 1'b1;
    #1 chk("midrst_async", o, 5'd0);
    step();
    chk("midrst_hold", o, 5'd0);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("restart%0d", i + 1), o, exp_seq[i]);
    end

`ifdef NLPRG_STEP_EN
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) step();
    chk("en_at9", o, 5'd9);
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("en_hold", o, 5'd9);
    end
    en = 1'b1;
    step();
    chk("en_resume", o, 5'd18);
    en = 1'b0;
    rst = 1'b1;
    #1 chk("en_rst_ovr", o, 5'd0);
    step();
    rst = 1'b0;
    en = 1'b1;
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
